// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop input synchronizer, mid-bit sampling and framing-error break handling
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic rx_m, rx_s;
  assign rx_busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      rx_byte   <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m      <= rx_pin;
      rx_s      <= rx_m;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          cnt   <= '0;
          state <= START;
        end
        // half a bit in, a high line means the falling edge was a glitch
        START: if (cnt == HALF_M1) begin
          cnt   <= '0;
          idx   <= '0;
          state <= rx_s ? IDLE : DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == FULL_M1) begin
          cnt     <= '0;
          sh[idx] <= rx_s;
          idx     <= idx + 1'b1;
          if (idx == 3'd7) state <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (cnt == FULL_M1) begin
          cnt <= '0;
          if (rx_s) begin
            rx_byte <= sh;
            rx_done <= 1'b1;
            state   <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= BREAK;
          end
        end else cnt <= cnt + 1'b1;
        // a low stop bit means a break; wait for the line to recover before hunting starts
        BREAK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; frames push expected pulses, a monitor pops them on rx_done/frame_err
module tb_uart_rx;
  logic clk = 1'b0, rst = 1'b1, rx_pin = 1'b1;
  logic [7:0] rx_byte;
  logic rx_done, rx_busy, frame_err;
  int compared = 0, mism = 0, cyc = 0;
  logic [7:0] good = 8'h00;
  typedef struct {logic kind; logic [7:0] data; int due;} ev_t;
  ev_t sb[$];

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst(rst), .rx_pin(rx_pin), .rx_byte(rx_byte),
    .rx_done(rx_done), .rx_busy(rx_busy), .frame_err(frame_err)
  );

  initial forever #50 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // kind 0 = rx_done, 1 = frame_err; data is the rx_byte required in that cycle
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rx_done || frame_err) begin
        compared++;
        if (rx_done && frame_err) begin
          mism++;
          $display("FAIL done_err_exclusive: got both high at cycle %0d, want at most one", cyc);
        end else if (sb.size() == 0) begin
          mism++;
          $display("FAIL unexpected_pulse: got done=%0b err=%0b byte=%02h at cycle %0d, want no pulse", rx_done, frame_err, rx_byte, cyc);
        end else begin
          e = sb.pop_front();
          if (frame_err != e.kind || rx_byte != e.data || (e.due >= 0 && (cyc - e.due > 2 || e.due - cyc > 2))) begin
            mism++;
            $display("FAIL pulse: got err=%0b byte=%02h cycle=%0d, want err=%0b byte=%02h cycle=%0d(+/-2)", frame_err, rx_byte, cyc, e.kind, e.data, e.due);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mism++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // bp is the bit period in time units; one clock cycle is 100 units
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bp, input bit align, input bit lat);
    if (align) @(negedge clk);
    sb.push_back('{kind: !stop, data: stop ? d : good, due: lat ? cyc + 155 : -1});
    if (stop) good = d;
    rx_pin = 1'b0;
    #bp;
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      #bp;
    end
    rx_pin = stop;
    #bp;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_byte"}, int'(rx_byte), 0);
    check({tag, "_done"}, int'(rx_done), 0);
    check({tag, "_busy"}, int'(rx_busy), 0);
    check({tag, "_err"}, int'(frame_err), 0);
  endtask

  initial begin
    int bc;
    logic [7:0] f;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h9A, 1'b1, 1600, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("byte_9a", int'(rx_byte), 'h9A);
    send_frame(8'h00, 1'b1, 1600, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1600, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("byte_ff", int'(rx_byte), 'hFF);
    bc = 0;
    @(negedge clk);
    rx_pin = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bc += int'(rx_busy);
    end
    rx_pin = 1'b1;
    repeat (30) begin
      @(negedge clk);
      bc += int'(rx_busy);
    end
    check("glitch_busy_4_to_12", int'(bc >= 4 && bc <= 12), 1);
    check("glitch_byte_kept", int'(rx_byte), 'hFF);
    send_frame(8'h55, 1'b0, 1600, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    check("break_busy_held", int'(rx_busy), 1);
    check("break_byte_kept", int'(rx_byte), 'hFF);
    rx_pin = 1'b1;
    repeat (5) @(negedge clk);
    check("break_released", int'(rx_busy), 0);
    send_frame(8'hA5, 1'b1, 1600, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("byte_a5", int'(rx_byte), 'hA5);
    f = 8'h3C;
    @(negedge clk);
    rx_pin = 1'b0;
    #1600;
    for (int i = 0; i < 4; i++) begin
      rx_pin = f[i];
      #1600;
    end
    rx_pin = f[4];
    #800;
    check("busy_before_rst", int'(rx_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rx_pin = 1'b1;
    @(negedge clk);
    check_reset("midframe_rst");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1600, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check("byte_c3", int'(rx_byte), 'hC3);
    send_frame(8'h9A, 1'b1, 1552, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    send_frame(8'h9A, 1'b1, 1648, 1'b1, 1'b0);
    repeat (30) @(negedge clk);
    check("byte_drift", int'(rx_byte), 'h9A);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
